// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and default sizes for the data cache controller
package dcache_pkg;

    localparam int DEF_NUM_SET = 8;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_CNT_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD_MISS,
        FILL,
        WR_MEM,
        WR_DONE
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - blocking read-miss refill and write-through store sequencer
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd_i,
    input  logic              cpu_wr_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [ADDR_W-1:0] cpu_wdata_i,
    output logic [ADDR_W-1:0] cpu_rdata_o,
    output logic              stall_o,
    input  logic              cache_hit_i,
    input  logic [ADDR_W-1:0] cache_rdata_i,
    output logic              fill_we_o,
    output logic [ADDR_W-1:0] fill_addr_o,
    output logic [ADDR_W-1:0] fill_data_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [ADDR_W-1:0] mem_wdata_o,
    input  logic [ADDR_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] wdata_q;
    logic [ADDR_W-1:0] rdata_q;
    logic              wr_hit_q;
    logic              hit_inc;
    logic              miss_inc;
    logic [ADDR_W-1:0] word_addr;

    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Only the IDLE cycle looks at cpu_*; later states work from these copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wr_hit_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_wr_i) begin
                        addr_q   <= cpu_addr_i;
                        wdata_q  <= cpu_wdata_i;
                        wr_hit_q <= cache_hit_i;
                    end else if (cpu_rd_i && !cache_hit_i) begin
                        addr_q <= cpu_addr_i;
                    end
                end
                RD_MISS: begin
                    if (mem_ack_i) begin
                        rdata_q <= mem_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are gated by rst so the IDLE decode cannot raise stall while held in reset.
    always_comb begin
        state_nxt   = state;
        stall_o     = 1'b0;
        cpu_rdata_o = '0;
        fill_we_o   = 1'b0;
        fill_addr_o = '0;
        fill_data_o = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (cpu_wr_i) begin
                        stall_o   = 1'b1;
                        state_nxt = WR_MEM;
                    end else if (cpu_rd_i) begin
                        if (cache_hit_i) begin
                            cpu_rdata_o = cache_rdata_i;
                            hit_inc     = 1'b1;
                        end else begin
                            stall_o   = 1'b1;
                            miss_inc  = 1'b1;
                            state_nxt = RD_MISS;
                        end
                    end
                end
                RD_MISS: begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = word_addr;
                    stall_o    = 1'b1;
                    if (mem_ack_i) begin
                        state_nxt = FILL;
                    end
                end
                FILL: begin
                    fill_we_o   = 1'b1;
                    fill_addr_o = addr_q;
                    fill_data_o = rdata_q;
                    cpu_rdata_o = rdata_q;
                    state_nxt   = IDLE;
                end
                WR_MEM: begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = word_addr;
                    mem_wdata_o = wdata_q;
                    stall_o     = 1'b1;
                    if (mem_ack_i) begin
                        state_nxt = WR_DONE;
                    end
                end
                WR_DONE: begin
                    // No-write-allocate: only refresh the line if the store hit.
                    fill_we_o   = wr_hit_q;
                    fill_addr_o = addr_q;
                    fill_data_o = wdata_q;
                    state_nxt   = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit_inc),
        .clr (1'b0),
        .q   (hit_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk (clk),
        .rst (rst),
        .inc (miss_inc),
        .clr (1'b0),
        .q   (miss_cnt_o)
    );

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed vector bench for dcache_ctrl
module tb_dcache_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_rd, cpu_wr, cache_hit, mem_ack;
    logic [31:0] cpu_addr, cpu_wdata, cache_rdata, mem_rdata;

    logic [31:0] cpu_rdata, fill_addr, fill_data, mem_addr, mem_wdata;
    logic        stall, fill_we, mem_req, mem_we;
    logic [31:0] hit_cnt, miss_cnt;

    logic [31:0] cpu_rdata4, fill_addr4, fill_data4, mem_addr4, mem_wdata4;
    logic        stall4, fill_we4, mem_req4, mem_we4;
    logic [3:0]  hit_cnt4, miss_cnt4;

    int checks   = 0;
    int failures = 0;

    dcache_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_rd_i      (cpu_rd),
        .cpu_wr_i      (cpu_wr),
        .cpu_addr_i    (cpu_addr),
        .cpu_wdata_i   (cpu_wdata),
        .cpu_rdata_o   (cpu_rdata),
        .stall_o       (stall),
        .cache_hit_i   (cache_hit),
        .cache_rdata_i (cache_rdata),
        .fill_we_o     (fill_we),
        .fill_addr_o   (fill_addr),
        .fill_data_o   (fill_data),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .mem_ack_i     (mem_ack),
        .hit_cnt_o     (hit_cnt),
        .miss_cnt_o    (miss_cnt)
    );

    dcache_ctrl #(.CNT_W(4)) u_dut4 (
        .clk           (clk),
        .rst           (rst),
        .cpu_rd_i      (cpu_rd),
        .cpu_wr_i      (cpu_wr),
        .cpu_addr_i    (cpu_addr),
        .cpu_wdata_i   (cpu_wdata),
        .cpu_rdata_o   (cpu_rdata4),
        .stall_o       (stall4),
        .cache_hit_i   (cache_hit),
        .cache_rdata_i (cache_rdata),
        .fill_we_o     (fill_we4),
        .fill_addr_o   (fill_addr4),
        .fill_data_o   (fill_data4),
        .mem_req_o     (mem_req4),
        .mem_we_o      (mem_we4),
        .mem_addr_o    (mem_addr4),
        .mem_wdata_o   (mem_wdata4),
        .mem_rdata_i   (mem_rdata),
        .mem_ack_i     (mem_ack),
        .hit_cnt_o     (hit_cnt4),
        .miss_cnt_o    (miss_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        hit;
        logic [31:0] crd;
        logic        ack;
        logic [31:0] mrd;
        logic        e_stall;
        logic [31:0] e_rdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_fwe;
        logic [31:0] e_faddr;
        logic [31:0] e_fdata;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic hit, input logic [31:0] crd,
                         input logic ack, input logic [31:0] mrd);
        cpu_rd      = rd;
        cpu_wr      = wr;
        cpu_addr    = addr;
        cpu_wdata   = wdata;
        cache_hit   = hit;
        cache_rdata = crd;
        mem_ack     = ack;
        mem_rdata   = mrd;
    endtask

    initial begin
        // rd wr addr wdata hit crd ack mrd | stall rdata req we maddr mwdata fwe faddr fdata
        vecs[0]  = '{0,0,32'h0,32'h0,0,32'h0,0,32'h0,          0,32'h0,0,0,32'h0,32'h0,0,32'h0,32'h0};
        vecs[1]  = '{1,0,32'h40,32'h0,1,32'hDEADBEEF,0,32'h0,  0,32'hDEADBEEF,0,0,32'h0,32'h0,0,32'h0,32'h0};
        vecs[2]  = '{1,0,32'h84,32'h0,0,32'h0,0,32'h0,         1,32'h0,0,0,32'h0,32'h0,0,32'h0,32'h0};
        vecs[3]  = '{1,0,32'h84,32'h0,0,32'h0,0,32'h0,         1,32'h0,1,0,32'h84,32'h0,0,32'h0,32'h0};
        vecs[4]  = '{1,0,32'h84,32'h0,0,32'h0,0,32'h0,         1,32'h0,1,0,32'h84,32'h0,0,32'h0,32'h0};
        vecs[5]  = '{1,0,32'h84,32'h0,0,32'h0,0,32'h0,         1,32'h0,1,0,32'h84,32'h0,0,32'h0,32'h0};
        vecs[6]  = '{1,0,32'h84,32'h0,0,32'h0,1,32'h12345678, 1,32'h0,1,0,32'h84,32'h0,0,32'h0,32'h0};
        vecs[7]  = '{1,0,32'h84,32'h0,0,32'h0,0,32'h0,         0,32'h12345678,0,0,32'h0,32'h0,1,32'h84,32'h12345678};
        vecs[8]  = '{0,0,32'h0,32'h0,0,32'h0,1,32'h55,         0,32'h0,0,0,32'h0,32'h0,0,32'h0,32'h0};
        vecs[9]  = '{0,1,32'h10,32'hA5A5A5A5,1,32'h0,0,32'h0,  1,32'h0,0,0,32'h0,32'h0,0,32'h0,32'h0};
        vecs[10] = '{0,1,32'h10,32'hA5A5A5A5,1,32'h0,1,32'h0,  1,32'h0,1,1,32'h10,32'hA5A5A5A5,0,32'h0,32'h0};
        vecs[11] = '{0,1,32'h10,32'hA5A5A5A5,1,32'h0,0,32'h0,  0,32'h0,0,0,32'h0,32'h0,1,32'h10,32'hA5A5A5A5};
        vecs[12] = '{0,1,32'h20,32'h5A5A5A5A,0,32'h0,0,32'h0,  1,32'h0,0,0,32'h0,32'h0,0,32'h0,32'h0};
        vecs[13] = '{0,1,32'h20,32'h5A5A5A5A,0,32'h0,1,32'h0,  1,32'h0,1,1,32'h20,32'h5A5A5A5A,0,32'h0,32'h0};
        vecs[14] = '{0,1,32'h20,32'h5A5A5A5A,0,32'h0,0,32'h0,  0,32'h0,0,0,32'h0,32'h0,0,32'h20,32'h5A5A5A5A};
        vecs[15] = '{1,1,32'h30,32'h0F0F0F0F,1,32'h11111111,0,32'h0, 1,32'h0,0,0,32'h0,32'h0,0,32'h0,32'h0};
        vecs[16] = '{1,1,32'h30,32'h0F0F0F0F,1,32'h11111111,1,32'h0, 1,32'h0,1,1,32'h30,32'h0F0F0F0F,0,32'h0,32'h0};
        vecs[17] = '{1,1,32'h30,32'h0F0F0F0F,1,32'h11111111,0,32'h0, 0,32'h0,0,0,32'h0,32'h0,1,32'h30,32'h0F0F0F0F};
        vecs[18] = '{1,0,32'h8B,32'h0,0,32'h0,0,32'h0,         1,32'h0,0,0,32'h0,32'h0,0,32'h0,32'h0};
        vecs[19] = '{1,0,32'h8B,32'h0,0,32'h0,1,32'hCAFEF00D, 1,32'h0,1,0,32'h88,32'h0,0,32'h0,32'h0};
        vecs[20] = '{1,0,32'h8B,32'h0,0,32'h0,0,32'h0,         0,32'hCAFEF00D,0,0,32'h0,32'h0,1,32'h8B,32'hCAFEF00D};
        vecs[21] = '{0,0,32'h0,32'h0,0,32'h0,0,32'h0,          0,32'h0,0,0,32'h0,32'h0,0,32'h0,32'h0};

        rst = 1'b1;
        drive(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        #3;
        chk("reset_stall", {31'b0, stall}, 32'h0);
        chk("reset_req", {31'b0, mem_req}, 32'h0);
        chk("reset_fill_we", {31'b0, fill_we}, 32'h0);
        chk("reset_rdata", cpu_rdata, 32'h0);
        chk("reset_hit_cnt", hit_cnt, 32'h0);
        chk("reset_miss_cnt", miss_cnt, 32'h0);
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                  vecs[i].hit, vecs[i].crd, vecs[i].ack, vecs[i].mrd);
            #2;
            chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].e_stall});
            chk($sformatf("v%0d_rdata", i), cpu_rdata, vecs[i].e_rdata);
            chk($sformatf("v%0d_req", i), {31'b0, mem_req}, {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d_we", i), {31'b0, mem_we}, {31'b0, vecs[i].e_we});
            chk($sformatf("v%0d_maddr", i), mem_addr, vecs[i].e_maddr);
            chk($sformatf("v%0d_mwdata", i), mem_wdata, vecs[i].e_mwdata);
            chk($sformatf("v%0d_fill_we", i), {31'b0, fill_we}, {31'b0, vecs[i].e_fwe});
            chk($sformatf("v%0d_fill_addr", i), fill_addr, vecs[i].e_faddr);
            chk($sformatf("v%0d_fill_data", i), fill_data, vecs[i].e_fdata);
            step();
        end
        chk("table_hit_cnt", hit_cnt, 32'd1);
        chk("table_miss_cnt", miss_cnt, 32'd2);

        // Address changes and a long memory wait must not disturb the latched request.
        drive(1, 0, 32'h100, 32'h0, 0, 32'h0, 0, 32'h0);
        step();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 32'h200, 32'h0, 0, 32'h0, 0, 32'h0);
            #2;
            chk($sformatf("hold%0d_req", i), {31'b0, mem_req}, 32'h1);
            chk($sformatf("hold%0d_maddr", i), mem_addr, 32'h100);
            step();
        end
        drive(1, 0, 32'h200, 32'h0, 0, 32'h0, 1, 32'h77);
        step();
        drive(1, 0, 32'h200, 32'h0, 0, 32'h0, 0, 32'h0);
        #2;
        chk("hold_fill_rdata", cpu_rdata, 32'h77);
        chk("hold_fill_addr", fill_addr, 32'h100);
        step();
        drive(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        step();
        chk("hold_miss_cnt", miss_cnt, 32'd3);

        // Asynchronous reset in the middle of a read miss.
        drive(1, 0, 32'h300, 32'h0, 0, 32'h0, 0, 32'h0);
        step();
        #2;
        chk("abort_pre_req", {31'b0, mem_req}, 32'h1);
        rst = 1'b1;
        #1;
        chk("abort_req", {31'b0, mem_req}, 32'h0);
        chk("abort_stall", {31'b0, stall}, 32'h0);
        step();
        rst = 1'b0;
        drive(1, 0, 32'h40, 32'h0, 1, 32'hDEADBEEF, 0, 32'h0);
        #2;
        chk("post_reset_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("post_reset_stall", {31'b0, stall}, 32'h0);
        chk("post_reset_req", {31'b0, mem_req}, 32'h0);
        step();
        drive(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        chk("post_reset_hit_cnt", hit_cnt, 32'd1);
        chk("post_reset_miss_cnt", miss_cnt, 32'd0);

        // Twenty immediate-ack misses; the 4-bit instance must stick at 15.
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 32'h400 + 32'(i * 4), 32'h0, 0, 32'h0, 0, 32'h0);
            step();
            drive(1, 0, 32'h400 + 32'(i * 4), 32'h0, 0, 32'h0, 1, 32'(i));
            step();
            drive(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
            step();
            if (i == 14) begin
                chk("sat_at_15", {28'b0, miss_cnt4}, 32'd15);
            end
        end
        chk("sat_miss_cnt4", {28'b0, miss_cnt4}, 32'd15);
        chk("sat_hit_cnt4", {28'b0, hit_cnt4}, 32'd1);
        chk("wide_miss_cnt", miss_cnt, 32'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Blocking miss/write controller for the direct-mapped data cache in the memory stage of the RISC-V pipeline.
- Sequences cache lookups, read-miss refills from data memory, and write-through stores.
- Stalls the pipeline while a memory transaction is outstanding.
- Keeps saturating hit and miss counters for performance inspection.

Parameters:
- NUM_SET, 8, number of cache sets. Informational only; the controller does no indexing itself.
- ADDR_W, 32, address and data width.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cpu_rd_i  in  1  load request in memory stage
- cpu_wr_i  in  1  store request in memory stage
- cpu_addr_i  in  ADDR_W  byte address; bits [1:0] ignored
- cpu_wdata_i  in  ADDR_W  store data
- cpu_rdata_o  out  ADDR_W  load result to writeback
- stall_o  out  1  freeze pipeline
- cache_hit_i  in  1  cache lookup hit for cpu_addr_i, combinational
- cache_rdata_i  in  ADDR_W  cache lookup data
- fill_we_o  out  1  write enable into cache tag/valid/data arrays
- fill_addr_o  out  ADDR_W  address of the cache write
- fill_data_o  out  ADDR_W  data of the cache write
- mem_req_o  out  1  data memory request
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  ADDR_W  word address, bits [1:0] forced to 0
- mem_wdata_o  out  ADDR_W  memory write data
- mem_rdata_i  in  ADDR_W  memory read data, valid with mem_ack_i
- mem_ack_i  in  1  memory completion
- hit_cnt_o  out  CNT_W  load hits
- miss_cnt_o  out  CNT_W  load misses

Behaviour:
- States: IDLE, RD_MISS, FILL, WR_MEM, WR_DONE.
- Reset values: state=IDLE; all outputs 0; counters 0; latched addr/data/hit registers 0.
- Reset mid-transaction: state returns to IDLE immediately and mem_req_o drops asynchronously. The memory side must discard the aborted request.

IDLE:
- rd & hit: cpu_rdata_o=cache_rdata_i, stall_o=0, hit_cnt++ ; stay in IDLE. Zero-wait hit.
- rd & !hit: stall_o=1 combinationally; latch addr; miss_cnt++ ; go to RD_MISS.
- wr: stall_o=1; latch addr, wdata, and wr_hit=cache_hit_i; go to WR_MEM.
- rd & wr together is illegal. wr wins and the read is ignored; no counter change.
- No request: all outputs 0.
- cpu_rdata_o=0 whenever no hit is returned.

RD_MISS:
- mem_req_o=1, mem_we_o=0, mem_addr_o=latched addr, stall_o=1.
- On mem_ack_i: latch mem_rdata_i, go to FILL.
- Waits indefinitely; no timeout.

FILL:
- fill_we_o=1, fill_addr_o=latched addr, fill_data_o=latched rdata.
- cpu_rdata_o=latched rdata, stall_o=0 (pipeline consumes the load this cycle); go to IDLE.

WR_MEM:
- mem_req_o=1, mem_we_o=1, mem_wdata_o=latched wdata, stall_o=1.
- On mem_ack_i go to WR_DONE.

WR_DONE:
- fill_we_o=wr_hit, fill_addr_o/fill_data_o=latched values. Write-through, no-write-allocate.
- stall_o=0; go to IDLE.

Timing and handshake rules:
- Latency with ack on the first request cycle: read miss 3 cycles, stall 2; store 3 cycles, stall 2. Each extra memory wait cycle adds 1.
- Handshake: mem_req_o and mem_addr_o/mem_we_o/mem_wdata_o stay stable until the cycle mem_ack_i is sampled high. mem_ack_i is ignored while mem_req_o=0. mem_req_o drops the cycle after ack.
- The pipeline holds cpu_* stable while stall_o=1. Only latched copies are used after IDLE.
- Counters saturate at all-ones and never wrap. They increment only on IDLE acceptance of a read.

Decomposition:
- Package dcache_pkg: state enum (IDLE, RD_MISS, FILL, WR_MEM, WR_DONE), ADDR_W, default NUM_SET, CNT_W.
- Sub-module sat_counter (parameter W; inputs inc, clr; output q) instantiated twice for the hit and miss counters.

Test Plan:
- Reset, then rd addr 0x40 with hit=1 and cache_rdata=0xDEADBEEF -> same-cycle cpu_rdata_o=0xDEADBEEF, stall_o=0, hit_cnt_o=1, mem_req_o never asserted.
- rd 0x84 with hit=0, memory acks after 3 wait cycles with 0x12345678 -> stall_o high for 5 cycles, mem_addr_o=0x84; FILL cycle fill_we_o=1, fill_data_o=0x12345678, cpu_rdata_o=0x12345678; miss_cnt_o=1.
- wr 0x10 data 0xA5A5A5A5 with hit=1, immediate ack -> mem_we_o=1, mem_wdata_o=0xA5A5A5A5; WR_DONE fill_we_o=1, fill_addr_o=0x10; counters unchanged. Repeat with hit=0 -> fill_we_o stays 0.
- Change cpu_addr_i during RD_MISS and hold mem_ack_i=0 for 10 cycles -> mem_addr_o stays at the latched value, mem_req_o stays high; toggles on mem_ack_i before req are ignored.
- Assert rst during RD_MISS -> mem_req_o=0 and stall_o=0 in the same cycle; next rd hit behaves as first scenario; counters=0.
- Preload miss counter near max (CNT_W=4 build), issue 20 misses -> miss_cnt_o holds at 15.
